// File: rtl/skin_pipe_sched.sv
// Flow-control scheduler around the fixed-latency chroma transform pipelines:
// credit-based issue, latency-matched tag shadow, result FIFO and pixel/frame counters.
module skin_pipe_sched #(
    parameter int LATENCY = 6,
    parameter int T_W     = 16,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_Y,
    input  logic [7:0]       in_Cb,
    input  logic [7:0]       in_Cr,
    input  logic             in_last,
    output logic [7:0]       dp_Y,
    output logic [7:0]       dp_Cb,
    output logic [7:0]       dp_Cr,
    input  logic [T_W-1:0]   dp_transcb,
    input  logic [T_W-1:0]   dp_transcr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [T_W-1:0]   out_transcb,
    output logic [T_W-1:0]   out_transcr,
    output logic [7:0]       out_Y,
    output logic             out_last,
    output logic [CNT_W-1:0] pix_count,
    output logic [CNT_W-1:0] frame_count,
    output logic             frame_done
);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FCW = $clog2(DEPTH + 1);
    localparam int IW  = $clog2(LATENCY + 1);
    localparam int SW  = $clog2(DEPTH + LATENCY + 1);
    localparam int EW  = 2 * T_W + 9;

    logic [LATENCY-1:0]      tag_valid_q, tag_valid_d;
    logic [LATENCY-1:0][7:0] tag_y_q, tag_y_d;
    logic [LATENCY-1:0]      tag_last_q, tag_last_d;
    logic [IW-1:0]           inflight_q, inflight_d;
    logic [FCW-1:0]          fifo_count_q, fifo_count_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        pix_count_q, pix_count_d;
    logic [CNT_W-1:0]        frame_count_q, frame_count_d;
    logic                    frame_done_q, frame_done_d;
    logic [EW-1:0]           mem_q [DEPTH];
    logic [EW-1:0]           head;
    logic                    accept;
    logic                    push;
    logic                    pop;

    assign dp_Y  = in_Y;
    assign dp_Cb = in_Cb;
    assign dp_Cr = in_Cr;

    // Every accepted pixel owns a slot either in the pipeline or in the FIFO,
    // so the FIFO can never be overrun while the consumer stalls.
    assign in_ready  = (SW'(fifo_count_q) + SW'(inflight_q)) < SW'(DEPTH);
    assign accept    = in_valid & in_ready;
    assign push      = tag_valid_q[LATENCY-1];
    assign out_valid = (fifo_count_q != '0);
    assign pop       = out_valid & out_ready;

    assign head = mem_q[rd_ptr_q];
    assign {out_transcb, out_transcr, out_Y, out_last} = head;

    assign pix_count   = pix_count_q;
    assign frame_count = frame_count_q;
    assign frame_done  = frame_done_q;

    always_comb begin
        tag_valid_d[0] = accept;
        tag_y_d[0]     = in_Y;
        tag_last_d[0]  = in_last;
        for (int i = 1; i < LATENCY; i++) begin
            tag_valid_d[i] = tag_valid_q[i-1];
            tag_y_d[i]     = tag_y_q[i-1];
            tag_last_d[i]  = tag_last_q[i-1];
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({accept, push})
            2'b10:   inflight_d = inflight_q + IW'(1);
            2'b01:   inflight_d = inflight_q - IW'(1);
            default: inflight_d = inflight_q;
        endcase

        fifo_count_d = fifo_count_q;
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + FCW'(1);
            2'b01:   fifo_count_d = fifo_count_q - FCW'(1);
            default: fifo_count_d = fifo_count_q;
        endcase

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    end

    always_comb begin
        pix_count_d   = pix_count_q;
        frame_count_d = frame_count_q;
        frame_done_d  = 1'b0;
        if (pop) begin
            if (out_last) begin
                pix_count_d   = '0;
                frame_count_d = frame_count_q + CNT_W'(1);
                frame_done_d  = 1'b1;
            end else begin
                pix_count_d   = pix_count_q + CNT_W'(1);
            end
        end
    end

    // Clearing the tags is what discards results still travelling through the unreset pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_q   <= '0;
            tag_y_q       <= '0;
            tag_last_q    <= '0;
            inflight_q    <= '0;
            fifo_count_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            pix_count_q   <= '0;
            frame_count_q <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            tag_valid_q   <= tag_valid_d;
            tag_y_q       <= tag_y_d;
            tag_last_q    <= tag_last_d;
            inflight_q    <= inflight_d;
            fifo_count_q  <= fifo_count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            pix_count_q   <= pix_count_d;
            frame_count_q <= frame_count_d;
            frame_done_q  <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {dp_transcb, dp_transcr, tag_y_q[LATENCY-1], tag_last_q[LATENCY-1]};
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (fifo_count_q == FCW'(DEPTH))));

    a_inflight_range: assert property (@(posedge clk) disable iff (!rst_n)
        inflight_q <= IW'(LATENCY));

endmodule

// File: doc/skin_pipe_sched.md
Name: skin_pipe_sched

Overview:
- Flow-control scheduler wrapped around the fixed-latency, non-stallable chroma transform pipelines (transcb/transcr).
- Accepts a pixel stream (Y, Cb, Cr) over a valid/ready handshake and issues pixels into the pipelines.
- Tags each issued pixel in a shadow shift register matching pipeline latency; captures results into an output FIFO.
- Uses credit accounting so no result is ever dropped while the downstream consumer stalls. Also counts pixels and frames for the skin-classifier stage.

Parameters:
- LATENCY, 6, clocks from pixel presented on dp_* inputs to result valid on dp_transcb/dp_transcr.
- T_W, 16, width of each transformed chroma value.
- DEPTH, 8, output FIFO entries; must be >= 2; power of two.
- CNT_W, 20, width of the pixel and frame counters.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream pixel valid.
- in_ready  out  1  scheduler can accept a pixel this cycle.
- in_Y, in_Cb, in_Cr  in  8 each  pixel components.
- in_last  in  1  marks last pixel of a frame.
- dp_Y, dp_Cb, dp_Cr  out  8 each  pipeline inputs.
- dp_transcb, dp_transcr  in  T_W each  pipeline outputs (signed).
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts head.
- out_transcb, out_transcr  out  T_W each  head results.
- out_Y  out  8  luma delayed to align with results.
- out_last  out  1  head is last pixel of a frame.
- pix_count  out  CNT_W  pixels popped in current frame.
- frame_count  out  CNT_W  frames completed.
- frame_done  out  1  one-cycle pulse after popping a last pixel.

Behaviour:
- Reset (rst_n low, asynchronous): tag shift register, inflight counter, FIFO pointers/count, pix_count, frame_count, frame_done all 0. Hence in_ready=1 and out_valid=0 after reset.
- Pipeline stages have no reset. Clearing the tags discards whatever those stages still hold; no result from before reset may reach out_*.
- dp_Y/dp_Cb/dp_Cr = in_Y/in_Cb/in_Cr combinationally, whether or not a pixel is accepted.
- accept = in_valid & in_ready.
- Tag shift register: LATENCY entries of {valid, Y, last}. Entry 0 loads {accept, in_Y, in_last} each clock; entries shift every clock. Entry LATENCY-1 valid means dp_transcb/dp_transcr hold that pixel's results this cycle.
- push = tag[LATENCY-1].valid; writes {dp_transcb, dp_transcr, tag.Y, tag.last} into the FIFO.
- pop = out_valid & out_ready; out_* show FIFO head (first-word-fall-through, registered storage).
- inflight counter: +1 on accept, -1 on push; both in the same cycle means no change. Range 0..LATENCY.
- Credit rule: in_ready = (fifo_count + inflight) < DEPTH, from registered state only. No combinational path from out_ready to in_ready.
  - Therefore push never occurs when the FIFO is full; this is asserted in simulation.
- Simultaneous push and pop: fifo_count unchanged. Pop takes the old head; push writes at the tail. Empty FIFO plus push: data is visible on out_* the next cycle, not the same cycle.
- Throughput: with out_ready held 1 and DEPTH >= 2, one pixel per clock sustained after fill. End-to-end latency from accept to out_valid is LATENCY+1 clocks.
- Counters:
  - On pop with out_last=0: pix_count += 1.
  - On pop with out_last=1: pix_count <= 0, frame_count += 1, frame_done = 1 next cycle only.
  - Both counters wrap modulo 2^CNT_W.
- in_last does not gate acceptance; a new frame may be accepted while the previous frame drains.
- Pointers wrap modulo DEPTH.

Test Plan:
- Reset then 16 back-to-back pixels (Cb=0x10+i, Y=0x80), out_ready=1 -> first out_valid 7 clocks after first accept. Outputs in order with out_Y=0x80 and results equal to the golden pipeline model. No bubbles after fill.
- out_ready=0 with 20 pixels offered -> exactly DEPTH=8 accepted and in_ready low thereafter. Release out_ready -> all 8 drain intact, then acceptance resumes; no loss or duplication.
- Random in_valid/out_ready (50% each), 1000 pixels -> scoreboard matches order and values; FIFO-overflow assertion never fires; inflight stays <= 6.
- 3 frames of 5 pixels, in_last on every 5th -> frame_done pulses 3 times, each one clock after the pop of a last pixel. pix_count sequence 1,2,3,4,0; frame_count ends at 3.
- Assert rst_n low asynchronously with 4 pixels in flight and 3 in the FIFO -> out_valid drops immediately and no stale result emerges after release. First new pixel appears LATENCY+1 clocks after its accept.
- FIFO at DEPTH-1 with push and pop in the same cycle -> count held at 7; head advances and the tail value is correct.
